// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters driving the select of a shared 4:1 mux.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles when others are waiting.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [2:0] win_idle;
  logic [2:0] win_next;

  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_arbiter4: MAX_HOLD must be at least 2");
  end

  // First set bit of m, searching upward from start with wrap; returns {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] m, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Idle search starts at ptr; hand-over search starts past the owner and excludes it.
  always_comb begin
    win_idle = pick(req, ptr);
    win_next = pick(req & ~gnt, sel + 2'd1);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 2'b00;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_idle[2]) begin
            gnt      <= 4'b0001 << win_idle[1:0];
            sel      <= win_idle[1:0];
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!req[sel]) begin
            ptr <= sel + 2'd1;
            if (win_next[2]) begin
              gnt      <= 4'b0001 << win_next[1:0];
              sel      <= win_next[1:0];
              hold_cnt <= '0;
            end else begin
              gnt   <= 4'b0000;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (hold_cnt == HOLD_LAST) begin
            // Hold limit reached: hand over only if someone else is waiting.
            if (win_next[2]) begin
              ptr      <= sel + 2'd1;
              gnt      <= 4'b0001 << win_next[1:0];
              sel      <= win_next[1:0];
              hold_cnt <= '0;
              timeout  <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'b00;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 2'b00;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_idle[2]) begin
            gnt   <= 4'b0001 << win_idle[1:0];
            sel   <= win_idle[1:0];
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Owner keeps the grant until it drops its request.
          if (!req[sel]) begin
            ptr <= sel + 2'd1;
            if (win_next[2]) begin
              gnt <= 4'b0001 << win_next[1:0];
              sel <= win_next[1:0];
            end else begin
              gnt   <= 4'b0000;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios plus random request traffic
// checked every cycle against a behavioural round-robin model.
module tb_rr_arbiter4;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int vectors;
  int errors;

  // Reference model state: owner index (-1 when idle), search start, grant age.
  int m_own;
  int m_ptr;
  int m_age;
  int m_sel;
  bit m_to;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [3:0] m, input int start);
    for (int k = 0; k < 4; k++) begin
      if (m[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit r, input logic [3:0] rq);
    int w;
    logic [3:0] others;
    m_to = 1'b0;
    if (r) begin
      m_own = -1; m_ptr = 0; m_age = 0; m_sel = 0;
    end else if (m_own < 0) begin
      w = first_req(rq, m_ptr);
      if (w >= 0) begin m_own = w; m_sel = w; m_age = 1; end
    end else if (!rq[m_own]) begin
      m_ptr = (m_own + 1) % 4;
      w = first_req(rq, m_ptr);
      m_own = w;
      if (w >= 0) begin m_sel = w; m_age = 1; end
    end else begin
      others = rq;
      others[m_own] = 1'b0;
`ifdef ARB_TIMEOUT_EN
      if (m_age >= MAX_HOLD && others != 4'b0000) begin
        m_ptr = (m_own + 1) % 4;
        w = first_req(others, m_ptr);
        m_own = w; m_sel = w; m_age = 1; m_to = 1'b1;
      end else begin
        m_age++;
      end
`else
      m_age++;
`endif
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, compare just after.
  task automatic step(input bit r, input logic [3:0] rq);
    logic [3:0] eg;
    @(negedge clk);
    reset = r;
    req   = rq;
    @(posedge clk);
    model_edge(r, rq);
    #1;
    eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
    check("gnt", 32'(gnt), 32'(eg));
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_own >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    logic [3:0] rq;
    bit         rs;
    vectors = 0;
    errors  = 0;
    m_own = -1; m_ptr = 0; m_age = 0; m_sel = 0; m_to = 1'b0;
    reset = 1'b1;
    req   = 4'b0000;

    // Reset with all requests asserted
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);

    // Single requester, then drop: sel must hold
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0100);
    check("single_gnt", 32'(gnt), 32'b0100);
    check("single_sel", 32'(sel), 32'd2);
    repeat (4) step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_sel", 32'(sel), 32'd2);

    // All request after reset; back-to-back rotation
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1111);
    check("rot0", 32'(gnt), 32'b0001);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1110);
    check("rot1", 32'(gnt), 32'b0010);
    step(1'b0, 4'b1110);
    step(1'b0, 4'b1100);
    check("rot2", 32'(gnt), 32'b0100);
    step(1'b0, 4'b1100);
    step(1'b0, 4'b1000);
    check("rot3", 32'(gnt), 32'b1000);
    check("rot3_sel", 32'(sel), 32'd3);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);

    // Wrap: owner 2 releases, ptr=3, then 3 beats 0
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1001);
    check("wrap3", 32'(gnt), 32'b1000);
    step(1'b0, 4'b1001);
    step(1'b0, 4'b0001);
    check("wrap0", 32'(gnt), 32'b0001);
    step(1'b0, 4'b0000);

    // Reset mid-grant
    step(1'b0, 4'b0010);
    check("mid_gnt", 32'(gnt), 32'b0010);
    step(1'b1, 4'b0010);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    step(1'b0, 4'b0010);
    check("mid_regrant", 32'(gnt), 32'b0010);

    // Hold limit with a competing requester
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0011);
    check("hold_last", 32'(gnt), 32'b0001);
    step(1'b0, 4'b0011);
`ifdef ARB_TIMEOUT_EN
    check("hold_to_gnt", 32'(gnt), 32'b0010);
    check("hold_to_pulse", 32'(timeout), 32'h1);
`else
    check("hold_to_gnt", 32'(gnt), 32'b0001);
    check("hold_to_pulse", 32'(timeout), 32'h0);
`endif
    step(1'b0, 4'b0011);
    check("hold_to_clear", 32'(timeout), 32'h0);

    // Random traffic: sticky requests that toggle occasionally, rare resets
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      rs = ($urandom_range(0, 99) == 0);
      step(rs, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
